// File: rtl/ofm_wr_master.sv
// AXI4 write master for the output-feature-map stream: splits a byte-count request into
// bursts, forwards stream beats onto W, and reports completion once every burst has a B response.
module ofm_wr_master #(
  parameter int DATA_WIDTH      = 512,
  parameter int DATA_WIDTH_BYTE = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH      = 64,
  parameter int BURST_LENGTH    = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wmst_req,
  input  logic [ADDR_WIDTH-1:0]      wmst_addr,
  input  logic [63:0]                wmst_xfer_size,
  output logic                       wmst_done,
  output logic                       busy,
  output logic                       err,
  input  logic [DATA_WIDTH-1:0]      tdata,
  input  logic                       valid,
  output logic                       ready,
  output logic                       m_axi_awvalid,
  input  logic                       m_axi_awready,
  output logic [ADDR_WIDTH-1:0]      m_axi_awaddr,
  output logic [7:0]                 m_axi_awlen,
  output logic                       m_axi_wvalid,
  input  logic                       m_axi_wready,
  output logic [DATA_WIDTH-1:0]      m_axi_wdata,
  output logic [DATA_WIDTH_BYTE-1:0] m_axi_wstrb,
  output logic                       m_axi_wlast,
  input  logic                       m_axi_bvalid,
  output logic                       m_axi_bready,
  input  logic [1:0]                 m_axi_bresp
);

  // state  | meaning
  // S_IDLE | waiting for wmst_req
  // S_RUN  | issuing AW bursts, forwarding W beats, collecting B responses
  // S_DONE | one-cycle wmst_done pulse

  localparam int BEAT_W     = 58;
  localparam int BYTE_SHIFT = $clog2(DATA_WIDTH_BYTE);
  localparam int PTR_W      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int FIFO_DEPTH = 1 << PTR_W;
  localparam int OUT_W      = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [BEAT_W-1:0] BURST_BEATS = BEAT_W'(BURST_LENGTH);
  localparam logic [8:0]        BURST_LEN9  = 9'(BURST_LENGTH);
  localparam logic [OUT_W-1:0]  OUT_MAX     = OUT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [BEAT_W-1:0]     aw_remain;
  logic [BEAT_W-1:0]     burst_cnt;
  logic [BEAT_W-1:0]     resp_cnt;
  logic [OUT_W-1:0]      outstanding;
  logic                  err_q;

  logic [8:0]            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        fifo_cnt;
  logic [8:0]            beat_cnt;

  logic [BEAT_W-1:0]     total_beats;
  logic [8:0]            burst_beats;
  logic [8:0]            head_len;
  logic                  aw_active;
  logic                  aw_hs;
  logic                  w_active;
  logic                  w_last;
  logic                  w_hs;
  logic                  b_hs;
  logic                  req_accept;

  // Round the byte count up to whole beats.
  assign total_beats = BEAT_W'(wmst_xfer_size >> BYTE_SHIFT)
                     + BEAT_W'(|wmst_xfer_size[BYTE_SHIFT-1:0]);

  assign burst_beats = (aw_remain < BURST_BEATS) ? aw_remain[8:0] : BURST_LEN9;
  assign head_len    = fifo_mem[rd_ptr];

  assign aw_active  = (state == S_RUN) && (aw_remain != '0) && (outstanding < OUT_MAX);
  assign aw_hs      = aw_active && m_axi_awready;
  assign w_active   = (fifo_cnt != '0);
  assign w_last     = w_active && (beat_cnt == (head_len - 9'd1));
  assign w_hs       = w_active && valid && m_axi_wready;
  assign b_hs       = (state == S_RUN) && m_axi_bvalid;
  assign req_accept = (state == S_IDLE) && wmst_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    busy          = 1'b0;
    wmst_done     = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_awvalid = aw_active;
    m_axi_awaddr  = cur_addr;
    m_axi_awlen   = 8'd0;
    m_axi_wvalid  = valid && w_active;
    m_axi_wdata   = tdata;
    m_axi_wstrb   = '1;
    m_axi_wlast   = w_last;
    ready         = m_axi_wready && w_active;
    err           = err_q;
    if (aw_active) begin
      m_axi_awlen = 8'(burst_beats - 9'd1);
    end
    case (state)
      S_IDLE: begin
        if (wmst_req) begin
          state_nxt = (total_beats == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        busy         = 1'b1;
        m_axi_bready = 1'b1;
        // Leave on the last response, using the count as it will be after this handshake.
        if (b_hs && (aw_remain == '0) && ((resp_cnt + BEAT_W'(1)) == burst_cnt)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        wmst_done = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr    <= '0;
      aw_remain   <= '0;
      burst_cnt   <= '0;
      resp_cnt    <= '0;
      outstanding <= '0;
      err_q       <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      beat_cnt    <= '0;
    end else begin
      if (req_accept) begin
        cur_addr    <= wmst_addr;
        aw_remain   <= total_beats;
        burst_cnt   <= '0;
        resp_cnt    <= '0;
        outstanding <= '0;
        err_q       <= 1'b0;
      end

      if (aw_hs) begin
        cur_addr  <= cur_addr + (ADDR_WIDTH'(burst_beats) << BYTE_SHIFT);
        aw_remain <= aw_remain - BEAT_W'(burst_beats);
        burst_cnt <= burst_cnt + BEAT_W'(1);
        wr_ptr    <= wr_ptr + PTR_W'(1);
      end

      if (aw_hs && !b_hs) begin
        outstanding <= outstanding + OUT_W'(1);
      end else if (!aw_hs && b_hs) begin
        outstanding <= outstanding - OUT_W'(1);
      end

      if (b_hs) begin
        resp_cnt <= resp_cnt + BEAT_W'(1);
        if (m_axi_bresp != 2'b00) begin
          err_q <= 1'b1;
        end
      end

      if (w_hs) begin
        if (w_last) begin
          beat_cnt <= '0;
          rd_ptr   <= rd_ptr + PTR_W'(1);
        end else begin
          beat_cnt <= beat_cnt + 9'd1;
        end
      end

      if (aw_hs && !(w_hs && w_last)) begin
        fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
      end else if (!aw_hs && w_hs && w_last) begin
        fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
      end
    end
  end

  // Burst lengths wait here between their AW handshake and their last W beat.
  always_ff @(posedge clk) begin
    if (aw_hs) begin
      fifo_mem[wr_ptr] <= burst_beats;
    end
  end

endmodule

// File: tb/tb_ofm_wr_master.sv
// Directed bench for ofm_wr_master: a small AXI slave and stream source model drive the
// DUT cycle by cycle, and expected bursts/beats are computed from each request.
module tb_ofm_wr_master;
  localparam int DW  = 512;
  localparam int DWB = DW / 8;
  localparam int AW  = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic           wmst_req;
  logic [AW-1:0]  wmst_addr;
  logic [63:0]    wmst_xfer_size;
  logic           wmst_done, busy, err;
  logic [DW-1:0]  tdata;
  logic           valid, ready;
  logic           m_axi_awvalid, m_axi_awready;
  logic [AW-1:0]  m_axi_awaddr;
  logic [7:0]     m_axi_awlen;
  logic           m_axi_wvalid, m_axi_wready;
  logic [DW-1:0]  m_axi_wdata;
  logic [DWB-1:0] m_axi_wstrb;
  logic           m_axi_wlast;
  logic           m_axi_bvalid, m_axi_bready;
  logic [1:0]     m_axi_bresp;

  ofm_wr_master dut (
    .clk(clk), .rst(rst),
    .wmst_req(wmst_req), .wmst_addr(wmst_addr), .wmst_xfer_size(wmst_xfer_size),
    .wmst_done(wmst_done), .busy(busy), .err(err),
    .tdata(tdata), .valid(valid), .ready(ready),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // knobs
  bit rand_gap, rand_wr, rand_aw;
  int b_limit, err_idx;

  // model state
  int          exp_len[$];
  logic [63:0] exp_addr[$];
  logic [63:0] aw_addr_q[$];
  int          aw_len_q[$];
  int cyc, src_n, src_total, w_n, w_b, w_in_b, aw_beats, b_pend, b_n;
  int data_err, last_err, proto_err, busy_cyc, done_n, done_cyc, last_b_cyc, first_aw_cyc;
  logic        err_at_done;
  logic        aw_wait;
  logic [63:0] aw_wait_addr;
  logic [7:0]  aw_wait_len;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int k);
    logic [31:0] w;
    w = 32'(k) ^ 32'h5A5A_0000;
    return {(DW/32){w}};
  endfunction

  task automatic reset_model(input logic [63:0] base, input logic [63:0] sz);
    longint rem;
    int l;
    logic [63:0] a;
    exp_len.delete(); exp_addr.delete(); aw_addr_q.delete(); aw_len_q.delete();
    rem = longint'((sz + 64'd63) / 64'd64);
    src_total = int'(rem);
    a = base;
    while (rem > 0) begin
      l = (rem > 64) ? 64 : int'(rem);
      exp_len.push_back(l);
      exp_addr.push_back(a);
      a = a + 64'(l * DWB);
      rem = rem - l;
    end
    cyc = 0; src_n = 0; w_n = 0; w_b = 0; w_in_b = 0; aw_beats = 0; b_pend = 0; b_n = 0;
    data_err = 0; last_err = 0; proto_err = 0; busy_cyc = 0; done_n = 0;
    done_cyc = -1; last_b_cyc = -100; first_aw_cyc = -1; err_at_done = 1'bx; aw_wait = 1'b0;
  endtask

  task automatic sample();
    logic exp_last;
    cyc++;
    if (!m_axi_wready && ready) proto_err++;
    if ((valid && ready) != (m_axi_wvalid && m_axi_wready)) proto_err++;
    if (aw_wait && (!m_axi_awvalid || m_axi_awaddr != aw_wait_addr || m_axi_awlen != aw_wait_len))
      proto_err++;
    aw_wait      = m_axi_awvalid && !m_axi_awready;
    aw_wait_addr = m_axi_awaddr;
    aw_wait_len  = m_axi_awlen;
    if (m_axi_awvalid && first_aw_cyc < 0) first_aw_cyc = cyc;
    if (m_axi_wvalid && m_axi_wready) begin
      if (w_n >= aw_beats) proto_err++;
      if (m_axi_wdata !== pat(w_n) || m_axi_wstrb !== '1) data_err++;
      exp_last = (w_b < exp_len.size()) && (w_in_b == exp_len[w_b] - 1);
      if (m_axi_wlast !== exp_last) last_err++;
      if (exp_last) begin
        w_b++;
        w_in_b = 0;
      end else begin
        w_in_b++;
      end
      if (m_axi_wlast) b_pend++;
      w_n++;
    end
    if (valid && ready) src_n++;
    if (m_axi_bvalid && m_axi_bready) begin
      b_pend--;
      b_n++;
      last_b_cyc = cyc;
    end
    if (m_axi_awvalid && m_axi_awready) begin
      aw_addr_q.push_back(m_axi_awaddr);
      aw_len_q.push_back(int'(m_axi_awlen));
      aw_beats += int'(m_axi_awlen) + 1;
    end
    if (busy) busy_cyc++;
    if (wmst_done) begin
      done_n++;
      done_cyc    = cyc;
      err_at_done = err;
    end
  endtask

  task automatic step();
    @(negedge clk);
    wmst_req      = 1'b0;
    tdata         = pat(src_n);
    valid         = (src_n < src_total) && (!rand_gap || $urandom_range(0, 2) != 0);
    m_axi_wready  = !rand_wr || ($urandom_range(0, 3) != 0);
    m_axi_awready = !rand_aw || ($urandom_range(0, 1) != 0);
    m_axi_bvalid  = (b_pend > 0) && (b_n < b_limit);
    m_axi_bresp   = (b_n == err_idx) ? 2'd2 : 2'd0;
    #1;
    sample();
  endtask

  task automatic start(input logic [63:0] a, input logic [63:0] sz);
    reset_model(a, sz);
    @(negedge clk);
    wmst_req       = 1'b1;
    wmst_addr      = a;
    wmst_xfer_size = sz;
    valid          = 1'b0;
    m_axi_bvalid   = 1'b0;
    m_axi_awready  = 1'b1;
    m_axi_wready   = 1'b1;
  endtask

  task automatic run_done(input int budget);
    for (int i = 0; i < budget && done_n == 0; i++) step();
    step();
    step();
  endtask

  task automatic check_run(input string tag, input logic exp_err);
    chk({tag, ":aw_count"}, 64'(aw_addr_q.size()), 64'(exp_len.size()));
    for (int i = 0; i < exp_len.size(); i++) begin
      if (i < aw_addr_q.size()) begin
        chk($sformatf("%s:aw%0d_addr", tag, i), aw_addr_q[i], exp_addr[i]);
        chk($sformatf("%s:aw%0d_len", tag, i), 64'(aw_len_q[i]), 64'(exp_len[i] - 1));
      end
    end
    chk({tag, ":w_beats"}, 64'(w_n), 64'(src_total));
    chk({tag, ":wlast_pos"}, 64'(last_err), 64'd0);
    chk({tag, ":wdata_order"}, 64'(data_err), 64'd0);
    chk({tag, ":protocol"}, 64'(proto_err), 64'd0);
    chk({tag, ":b_count"}, 64'(b_n), 64'(exp_len.size()));
    chk({tag, ":first_aw_lat"}, 64'(first_aw_cyc), 64'd1);
    chk({tag, ":done_lat"}, 64'(done_cyc - last_b_cyc), 64'd1);
    chk({tag, ":done_pulses"}, 64'(done_n), 64'd1);
    chk({tag, ":err_at_done"}, 64'(err_at_done), 64'(exp_err));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ":awvalid"}, 64'(m_axi_awvalid), 64'd0);
    chk({tag, ":wvalid"}, 64'(m_axi_wvalid), 64'd0);
    chk({tag, ":ready"}, 64'(ready), 64'd0);
    chk({tag, ":bready"}, 64'(m_axi_bready), 64'd0);
    chk({tag, ":wlast"}, 64'(m_axi_wlast), 64'd0);
    chk({tag, ":done"}, 64'(wmst_done), 64'd0);
    chk({tag, ":busy"}, 64'(busy), 64'd0);
    chk({tag, ":err"}, 64'(err), 64'd0);
    chk({tag, ":awaddr"}, m_axi_awaddr, 64'd0);
    chk({tag, ":awlen"}, 64'(m_axi_awlen), 64'd0);
  endtask

  initial begin
    rst = 1'b1; wmst_req = 1'b0; wmst_addr = '0; wmst_xfer_size = '0;
    tdata = '0; valid = 1'b0; m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    m_axi_bvalid = 1'b0; m_axi_bresp = 2'd0;
    rand_gap = 0; rand_wr = 0; rand_aw = 0; b_limit = 1 << 20; err_idx = -1;
    reset_model(64'd0, 64'd0);
    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // two full bursts
    start(64'h1000, 64'd8192);
    run_done(2000);
    check_run("full2", 1'b0);

    // 64 beats plus a single-beat tail burst
    start(64'h1000, 64'd4160);
    run_done(2000);
    check_run("tail1", 1'b0);

    // zero-length request
    start(64'h2000, 64'd0);
    run_done(20);
    chk("zero:no_awvalid", 64'(first_aw_cyc), 64'(-1));
    chk("zero:done_lat", 64'(done_cyc), 64'd1);
    chk("zero:done_pulses", 64'(done_n), 64'd1);
    chk("zero:busy_cycles", 64'(busy_cyc), 64'd1);

    // outstanding limit with B withheld
    b_limit = 0;
    start(64'h0, 64'd24576);
    repeat (600) step();
    chk("outst:aw_count_held", 64'(aw_addr_q.size()), 64'd4);
    chk("outst:awvalid_low", 64'(m_axi_awvalid), 64'd0);
    chk("outst:w_beats_held", 64'(w_n), 64'd256);
    b_limit = 1;
    repeat (20) step();
    chk("outst:aw_after_one_b", 64'(aw_addr_q.size()), 64'd5);
    b_limit = 1 << 20;
    run_done(3000);
    check_run("outst", 1'b0);

    // error response on the second burst
    err_idx = 1;
    start(64'h0, 64'd8192);
    run_done(2000);
    check_run("berr", 1'b1);
    chk("berr:sticky", 64'(err), 64'd1);
    err_idx = -1;

    // random stream gaps, W and AW backpressure; err must clear on the new request
    rand_gap = 1; rand_wr = 1; rand_aw = 1;
    start(64'h10000, 64'd8392);
    run_done(5000);
    check_run("rand", 1'b0);
    rand_gap = 0; rand_wr = 0; rand_aw = 0;

    // reset in the middle of a transfer, then a fresh transfer
    start(64'h1000, 64'd8192);
    for (int i = 0; i < 500 && w_n < 30; i++) step();
    chk("rst:reached_mid", 64'(w_n >= 30), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_zero("rst_mid");
    rst = 1'b0;
    start(64'h3000, 64'd4160);
    run_done(2000);
    check_run("after_rst", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
